prt_dptx_trn_gen: RTL and testbench
===================================

# prt_dptx_trn_gen

Link-domain training and test pattern generator for the DP TX path. It sits between the TX scrambler/framer and the PHY and drives the per-lane symbol bus in the same 9-bit-per-symbol format the RX link consumes. In normal operation it passes scrambled main-link symbols through. During link training it substitutes TPS1 or TPS2, or a PRBS7 symbol-error pattern. Pattern changes are glitch-free: a TPS2 period is never truncated.

## Interface
Parameters:
- P_LANES, 4, lane count (1, 2 or 4)
- P_SPL, 2, symbols per lane per clock (1, 2 or 4)

Ports:
- CLK_IN  in  1  link clock; the only clock in this block
- RST_IN  in  1  reset, synchronous, active-high
- CTL_TPS_IN  in  2  requested pattern: 0 = pass-through, 1 = TPS1, 2 = TPS2, 3 = PRBS7
- CTL_LANES_IN  in  3  active lanes: 1, 2 or 4; any other value is treated as 1
- LNK_DAT_IN  in  P_LANES*P_SPL*9  main-link symbols from the scrambler
- LNK_DAT_OUT  out  P_LANES*P_SPL*9  symbols to the PHY
- STA_TPS_OUT  out  2  pattern actually being driven, same encoding as CTL_TPS_IN

## Operation
- Symbol packing: lane i, symbol j occupies bits [(i*P_SPL+j)*9 +: 9]. Bit 8 is the K flag; bits 7:0 are the data. Symbol j is transmitted before j+1.
- Mode register `cur_tps` is set by the switch rules below. STA_TPS_OUT = `cur_tps`.
- Pass-through (0): each output symbol is LNK_DAT_IN registered.
- TPS1 (1): every symbol is D10.2, i.e. K = 0, data 8'h4A.
- TPS2 (2): 10-symbol period indexed by `sym_idx` (0..9):
  - idx 0 and 2: K28.5 (K = 1, 8'hBC)
  - idx 1 and 3: D11.6 (K = 0, 8'hCB)
  - idx 4..9: D10.2
  - Running disparity is resolved by the PHY encoder.
  - Symbol j in a clock uses index (sym_idx + j) mod 10. sym_idx then advances by P_SPL mod 10.
- PRBS7 (3): polynomial x^7 + x^6 + 1, seed 7'h7F, K = 0 on every symbol.
  - Each symbol consumes 8 consecutive LFSR output bits; the first bit goes to data bit 0.
  - The LFSR advances 8*P_SPL bits per clock.
  - All active lanes carry identical PRBS symbols.
- Inactive lanes (lane index ≥ active count) output 9'h000 in every mode.
- Switch rules (a request is a CTL_TPS_IN value that differs from `cur_tps`):
  - If `cur_tps` ≠ 2, `cur_tps` takes the request at the next clock edge.
  - If `cur_tps` = 2, the switch is deferred until the clock in which sym_idx = 0. That is the first symbol of a new period, so the previous period is always complete.
  - If the request changes again while a switch is deferred, the latest value wins.
- Entering TPS2 loads sym_idx = 0. Entering PRBS7 loads LFSR = 7'h7F. Both loads take effect in the clock the mode changes.
- CTL_LANES_IN takes effect at the next edge, independent of pattern switching.

## Timing
- All outputs are registered. A pattern becomes visible on LNK_DAT_OUT in the same cycle STA_TPS_OUT changes, which is one clock after it is accepted.
- Pass-through latency: 1 clock from LNK_DAT_IN to LNK_DAT_OUT.
- TPS2 period in clocks: P_SPL = 1 → 10, P_SPL = 2 → 5, P_SPL = 4 → 5. For P_SPL = 4, sym_idx runs 0, 4, 8, 2, 6.
- Worst-case deferred switch out of TPS2: period − 1 extra clocks.
- Reset values: LNK_DAT_OUT = 0, STA_TPS_OUT = 0, cur_tps = 0, sym_idx = 0, LFSR = 7'h7F.
- Reset asserted mid-pattern: outputs are 0 on the next edge. Any pending switch is discarded.
- Simultaneous reset and request: reset wins.

## Configuration
- Macro `PRT_DPTX_TRN_PRBS7_EN`.
- Defined: PRBS7 mode, including the LFSR, is compiled in.
- Undefined: the LFSR logic is removed. A request of 3 is treated as 1 (TPS1), and STA_TPS_OUT reports 1.

## Test plan
- Reset, then pass-through with P_LANES = 4, P_SPL = 2 and a ramp on LNK_DAT_IN → LNK_DAT_OUT equals the input delayed exactly 1 clock. STA_TPS_OUT = 0 throughout.
- CTL_TPS_IN = 1 → from the next clock, all 8 symbols are 9'h04A and STA_TPS_OUT = 1.
- CTL_TPS_IN = 2 with P_SPL = 2 → lane 0 repeats every 5 clocks: {1BC,0CB}, {1BC,0CB}, {04A,04A}, {04A,04A}, {04A,04A}. Request 0 two clocks into the period → STA_TPS_OUT stays 2 for 3 more clocks, then 0.
- P_SPL = 4 in TPS2 → the symbol stream per lane repeats with period 10 symbols, K28.5 at stream positions 0 and 2 mod 10.
- CTL_LANES_IN = 2 in TPS1 → lanes 2 and 3 output 9'h000; lanes 0 and 1 output 9'h04A. CTL_LANES_IN = 5 behaves as 1.
- With PRBS7_EN, CTL_TPS_IN = 3 → the first symbol matches the reference LFSR from seed 7'h7F, and the stream repeats every 127 symbols. Without the macro → 9'h04A and STA_TPS_OUT = 1.

Source files
------------

// File: rtl/prt_dptx_trn_gen.sv
// DP TX link training / test pattern generator: pass-through, TPS1, TPS2 and PRBS7.
// Optional PRBS7 mode and its LFSR are compiled in with `define PRT_DPTX_TRN_PRBS7_EN.
module prt_dptx_trn_gen #(
  parameter int P_LANES = 4,
  parameter int P_SPL   = 2
) (
  input  logic                       CLK_IN,
  input  logic                       RST_IN,
  input  logic [1:0]                 CTL_TPS_IN,
  input  logic [2:0]                 CTL_LANES_IN,
  input  logic [P_LANES*P_SPL*9-1:0] LNK_DAT_IN,
  output logic [P_LANES*P_SPL*9-1:0] LNK_DAT_OUT,
  output logic [1:0]                 STA_TPS_OUT
);

  localparam int         W        = P_LANES * P_SPL * 9;
  localparam logic [8:0] SYM_K285 = 9'h1BC;
  localparam logic [8:0] SYM_D116 = 9'h0CB;
  localparam logic [8:0] SYM_D102 = 9'h04A;
  localparam logic [3:0] IDX_STEP = 4'(P_SPL % 10);

  logic [1:0]         cur_tps_reg;
  logic [1:0]         cur_tps_next;
  logic [1:0]         req_tps;
  logic               switch_now;
  logic [3:0]         sym_idx_reg;
  logic [3:0]         sym_idx_next;
  logic [3:0]         tps2_base;
  logic [3:0]         tps2_pos;
  logic [3:0]         idx_adv;
  logic [W-1:0]       dat_reg;
  logic [W-1:0]       dat_next;
  logic [2:0]         active_cnt;
  logic [P_LANES-1:0] lane_on;
  logic [8:0]         tps2_sym [P_SPL];
  logic [8:0]         prbs_sym [P_SPL];

  always_comb begin
    req_tps = CTL_TPS_IN;
`ifndef PRT_DPTX_TRN_PRBS7_EN
    if (CTL_TPS_IN == 2'd3) req_tps = 2'd1;
`endif
  end

  // Leaving TPS2 waits for a period boundary so a TPS2 period is never cut short.
  assign switch_now   = (req_tps != cur_tps_reg) &&
                        ((cur_tps_reg != 2'd2) || (sym_idx_reg == 4'd0));
  assign cur_tps_next = switch_now ? req_tps : cur_tps_reg;

  always_comb begin
    active_cnt = 3'd1;
    if (CTL_LANES_IN == 3'd2) active_cnt = 3'd2;
    if (CTL_LANES_IN == 3'd4) active_cnt = 3'd4;
  end

  always_comb begin
    tps2_base = (switch_now && (req_tps == 2'd2)) ? 4'd0 : sym_idx_reg;
    tps2_pos  = 4'd0;
    for (int j = 0; j < P_SPL; j++) begin
      tps2_pos = tps2_base + 4'(j);
      if (tps2_pos >= 4'd10) tps2_pos = tps2_pos - 4'd10;
      if ((tps2_pos == 4'd0) || (tps2_pos == 4'd2))
        tps2_sym[j] = SYM_K285;
      else if ((tps2_pos == 4'd1) || (tps2_pos == 4'd3))
        tps2_sym[j] = SYM_D116;
      else
        tps2_sym[j] = SYM_D102;
    end
    idx_adv = tps2_base + IDX_STEP;
    if (idx_adv >= 4'd10) idx_adv = idx_adv - 4'd10;
    sym_idx_next = (cur_tps_next == 2'd2) ? idx_adv : sym_idx_reg;
  end

`ifdef PRT_DPTX_TRN_PRBS7_EN
  logic [6:0] lfsr_reg;
  logic [6:0] lfsr_next;
  logic [6:0] prbs_state;
  logic       prbs_fb;

  // x^7 + x^6 + 1, newest bit shifted into bit 0; each output bit fills data LSB first.
  always_comb begin
    prbs_state = (switch_now && (req_tps == 2'd3)) ? 7'h7F : lfsr_reg;
    prbs_fb    = 1'b0;
    for (int j = 0; j < P_SPL; j++) begin
      prbs_sym[j] = 9'h000;
      for (int b = 0; b < 8; b++) begin
        prbs_fb        = prbs_state[6] ^ prbs_state[5];
        prbs_sym[j][b] = prbs_fb;
        prbs_state     = {prbs_state[5:0], prbs_fb};
      end
    end
    lfsr_next = (cur_tps_next == 2'd3) ? prbs_state : lfsr_reg;
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) lfsr_reg <= 7'h7F;
    else        lfsr_reg <= lfsr_next;
  end
`else
  always_comb begin
    for (int j = 0; j < P_SPL; j++) prbs_sym[j] = SYM_D102;
  end
`endif

  for (genvar gi = 0; gi < P_LANES; gi++) begin : g_lane
    assign lane_on[gi] = (gi < int'(active_cnt));
    for (genvar gj = 0; gj < P_SPL; gj++) begin : g_sym
      localparam int LSB = (gi * P_SPL + gj) * 9;
      logic [8:0] pat;
      always_comb begin
        case (cur_tps_next)
          2'd0:    pat = LNK_DAT_IN[LSB +: 9];
          2'd2:    pat = tps2_sym[gj];
          2'd3:    pat = prbs_sym[gj];
          default: pat = SYM_D102;
        endcase
      end
      assign dat_next[LSB +: 9] = lane_on[gi] ? pat : 9'h000;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      cur_tps_reg <= 2'd0;
      sym_idx_reg <= 4'd0;
      dat_reg     <= '0;
    end else begin
      cur_tps_reg <= cur_tps_next;
      sym_idx_reg <= sym_idx_next;
      dat_reg     <= dat_next;
    end
  end

  assign LNK_DAT_OUT = dat_reg;
  assign STA_TPS_OUT = cur_tps_reg;

endmodule

// File: tb/tb_prt_dptx_trn_gen.sv
// Directed bench for prt_dptx_trn_gen: vector table plus TPS2 / reset / PRBS7 sequences.
module tb_prt_dptx_trn_gen;

  localparam logic [8:0] K285 = 9'h1BC;
  localparam logic [8:0] D116 = 9'h0CB;
  localparam logic [8:0] D102 = 9'h04A;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   ctl_tps;
  logic [2:0]   ctl_lanes;
  logic [71:0]  din;
  logic [71:0]  dout;
  logic [1:0]   sta;
  logic [143:0] din4;
  logic [143:0] dout4;
  logic [1:0]   sta4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prt_dptx_trn_gen #(.P_LANES(4), .P_SPL(2)) dut (
    .CLK_IN(clk), .RST_IN(rst), .CTL_TPS_IN(ctl_tps), .CTL_LANES_IN(ctl_lanes),
    .LNK_DAT_IN(din), .LNK_DAT_OUT(dout), .STA_TPS_OUT(sta)
  );

  prt_dptx_trn_gen #(.P_LANES(4), .P_SPL(4)) dut4 (
    .CLK_IN(clk), .RST_IN(rst), .CTL_TPS_IN(ctl_tps), .CTL_LANES_IN(ctl_lanes),
    .LNK_DAT_IN(din4), .LNK_DAT_OUT(dout4), .STA_TPS_OUT(sta4)
  );

  typedef struct {
    logic [1:0]  tps;
    logic [2:0]  lanes;
    logic [71:0] din;
    logic [1:0]  exp_sta;
    logic [71:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [71:0] ramp(input int base);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k*9 +: 9] = 9'((base + k * 37) & 'h1FF);
    return w;
  endfunction

  function automatic logic [71:0] keep_lanes(input logic [71:0] d, input int n);
    logic [71:0] w;
    w = d;
    for (int l = n; l < 4; l++) w[l*18 +: 18] = '0;
    return w;
  endfunction

  function automatic logic [71:0] fill2(input logic [8:0] s0, input logic [8:0] s1, input int n);
    logic [71:0] w;
    w = '0;
    for (int l = 0; l < n; l++) begin
      w[(l*2)*9 +: 9]   = s0;
      w[(l*2+1)*9 +: 9] = s1;
    end
    return w;
  endfunction

  function automatic logic [8:0] tps2_ref(input int pos);
    int p;
    p = pos % 10;
    if (p == 0 || p == 2) return K285;
    if (p == 1 || p == 3) return D116;
    return D102;
  endfunction

  task automatic add(input logic [1:0] t, input logic [2:0] n, input logic [71:0] d,
                     input logic [1:0] es, input logic [71:0] ed);
    vec_t v;
    v.tps = t; v.lanes = n; v.din = d; v.exp_sta = es; v.exp_dout = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

`ifdef PRT_DPTX_TRN_PRBS7_EN
  logic       prbs_bits [127];
  logic [8:0] prbs_hist [140];
`endif

  initial begin
    rst = 1'b1; ctl_tps = 2'd0; ctl_lanes = 3'd4; din = '0;
    din4 = {ramp(3), ramp(9)};

    add(2'd0, 3'd4, ramp(0),   2'd0, ramp(0));
    add(2'd0, 3'd4, ramp(8),   2'd0, ramp(8));
    add(2'd0, 3'd2, ramp(100), 2'd0, keep_lanes(ramp(100), 2));
    add(2'd1, 3'd4, ramp(5),   2'd1, fill2(D102, D102, 4));
    add(2'd1, 3'd2, ramp(6),   2'd1, fill2(D102, D102, 2));
    add(2'd1, 3'd5, ramp(7),   2'd1, fill2(D102, D102, 1));
    add(2'd1, 3'd0, ramp(9),   2'd1, fill2(D102, D102, 1));
    add(2'd2, 3'd4, ramp(10),  2'd2, fill2(K285, D116, 4));
    add(2'd2, 3'd4, ramp(11),  2'd2, fill2(K285, D116, 4));
    add(2'd2, 3'd4, ramp(12),  2'd2, fill2(D102, D102, 4));
    add(2'd2, 3'd4, ramp(13),  2'd2, fill2(D102, D102, 4));
    add(2'd2, 3'd4, ramp(14),  2'd2, fill2(D102, D102, 4));
    add(2'd2, 3'd4, ramp(15),  2'd2, fill2(K285, D116, 4));
    add(2'd2, 3'd4, ramp(16),  2'd2, fill2(K285, D116, 4));
    add(2'd0, 3'd4, ramp(20),  2'd2, fill2(D102, D102, 4));
    add(2'd0, 3'd4, ramp(30),  2'd2, fill2(D102, D102, 4));
    add(2'd0, 3'd4, ramp(40),  2'd2, fill2(D102, D102, 4));
    add(2'd1, 3'd4, ramp(50),  2'd1, fill2(D102, D102, 4));
    add(2'd0, 3'd4, ramp(60),  2'd0, ramp(60));
`ifndef PRT_DPTX_TRN_PRBS7_EN
    add(2'd3, 3'd4, ramp(70),  2'd1, fill2(D102, D102, 4));
    add(2'd0, 3'd4, ramp(80),  2'd0, ramp(80));
`endif

    tick; tick; tick;
    check("reset_dout",  {72'd0, dout}, 144'd0);
    check("reset_sta",   {142'd0, sta}, 144'd0);
    check("reset_dout4", dout4, 144'd0);
    check("reset_sta4",  {142'd0, sta4}, 144'd0);

    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      ctl_tps = vecs[i].tps; ctl_lanes = vecs[i].lanes; din = vecs[i].din;
      tick;
      check($sformatf("vec%0d_sta", i),  {142'd0, sta}, {142'd0, vecs[i].exp_sta});
      check($sformatf("vec%0d_dout", i), {72'd0, dout}, {72'd0, vecs[i].exp_dout});
    end

    // Four symbols per clock: the per-lane stream must still follow the 10-symbol TPS2 period.
    ctl_tps = 2'd1; ctl_lanes = 3'd4;
    tick;
    ctl_tps = 2'd2;
    for (int c = 0; c < 10; c++) begin
      tick;
      check($sformatf("spl4_c%0d_sta", c), {142'd0, sta4}, 144'd2);
      for (int l = 0; l < 4; l += 3) begin
        logic [35:0] exp_lane;
        for (int j = 0; j < 4; j++) exp_lane[j*9 +: 9] = tps2_ref(c * 4 + j);
        check($sformatf("spl4_c%0d_lane%0d", c, l), {108'd0, dout4[l*36 +: 36]}, {108'd0, exp_lane});
      end
    end

    // Reset together with a request: reset wins and clears everything.
    ctl_tps = 2'd1; rst = 1'b1;
    tick;
    check("rst_mid_dout", {72'd0, dout}, 144'd0);
    check("rst_mid_sta",  {142'd0, sta}, 144'd0);
    check("rst_mid_dout4", dout4, 144'd0);
    rst = 1'b0; ctl_tps = 2'd2;
    tick;
    check("post_rst_sta",  {142'd0, sta}, 144'd2);
    check("post_rst_dout", {72'd0, dout}, {72'd0, fill2(K285, D116, 4)});

    // Request issued right after the first clock of a period: worst-case deferral.
    ctl_tps = 2'd0; din = ramp(200);
    for (int k = 0; k < 4; k++) begin
      tick;
      check($sformatf("defer%0d_sta", k), {142'd0, sta}, 144'd2);
      check($sformatf("defer%0d_dout", k), {72'd0, dout},
            {72'd0, (k == 0) ? fill2(K285, D116, 4) : fill2(D102, D102, 4)});
    end
    tick;
    check("defer_done_sta",  {142'd0, sta}, 144'd0);
    check("defer_done_dout", {72'd0, dout}, {72'd0, ramp(200)});

`ifdef PRT_DPTX_TRN_PRBS7_EN
    begin
      logic h [134];
      for (int i = 0; i < 7; i++) h[i] = 1'b1;
      for (int i = 7; i < 134; i++) h[i] = h[i-7] ^ h[i-6];
      for (int n = 0; n < 127; n++) prbs_bits[n] = h[n+7];
    end
    ctl_tps = 2'd3;
    for (int c = 0; c < 70; c++) begin
      tick;
      check($sformatf("prbs_c%0d_sta", c), {142'd0, sta}, 144'd3);
      for (int j = 0; j < 2; j++) begin
        int k;
        logic [8:0] e;
        k = c * 2 + j;
        e = 9'h000;
        for (int b = 0; b < 8; b++) e[b] = prbs_bits[(8 * k + b) % 127];
        prbs_hist[k] = dout[j*9 +: 9];
        check($sformatf("prbs_s%0d_l0", k), {135'd0, dout[j*9 +: 9]}, {135'd0, e});
        check($sformatf("prbs_s%0d_l3", k), {135'd0, dout[(6+j)*9 +: 9]}, {135'd0, e});
        if (k >= 127)
          check($sformatf("prbs_s%0d_rep", k), {135'd0, prbs_hist[k]}, {135'd0, prbs_hist[k-127]});
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
